ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter RAM_ADDRESS_BITS, default 8: RAM address width.
REQ-002 SHALL have parameter RAM_SIZE, default 256: number of RAM words (2**RAM_ADDRESS_BITS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a load; sampled in IDLE only.
REQ-006 SHALL have port start_addr, input, RAM_ADDRESS_BITS bits: first RAM address, sampled with start.
REQ-007 SHALL have port length, input, RAM_ADDRESS_BITS+1 bits: byte count 0..RAM_SIZE, sampled with start.
REQ-008 SHALL have port byte_in, input, 8 bits: program byte from the source.
REQ-009 SHALL have port byte_valid, input, 1 bit: source holds a valid byte_in.
REQ-010 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-011 SHALL have port GLOBAL_BUS, output, 8 bits: value driven onto the computer's global bus.
REQ-012 SHALL have port bus_drive, output, 1 bit: GLOBAL_BUS is valid and owned by the loader.
REQ-013 SHALL have port mar_in, output, 1 bit: memory address register load strobe.
REQ-014 SHALL have port ram_in, output, 1 bit: RAM write strobe.
REQ-015 SHALL have port RESETn, output, 1 bit: active-low CPU reset, held low while loading.
REQ-016 SHALL have port RESET_counter, output, 1 bit: microcode step counter reset pulse.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse on load completion.

Function
REQ-019 SHALL implement the states IDLE, WAIT_BYTE, ADDR, DATA and FINISH.
REQ-020 IDLE: on start=1 with length>0, SHALL latch start_addr, length and count=0, and go to WAIT_BYTE; on start=1 with length=0, SHALL go straight to FINISH.
REQ-021 WAIT_BYTE: byte_ready=1; on byte_valid&byte_ready at a clock edge, SHALL latch byte_in and go to ADDR; otherwise SHALL stay, with no timeout.
REQ-022 ADDR: SHALL drive GLOBAL_BUS={zero-extend, current address}, bus_drive=1 and mar_in=1 for exactly one cycle, then go to DATA.
REQ-023 DATA: SHALL drive GLOBAL_BUS=latched byte, bus_drive=1 and ram_in=1 for exactly one cycle; if count==length-1, SHALL go to FINISH; otherwise SHALL increment count and address and go to WAIT_BYTE.
REQ-024 Throughput SHALL be 3 cycles per byte: acceptance edge N, mar_in in cycle N+1, ram_in in cycle N+2, byte_ready high again in cycle N+3.
REQ-025 Address increment SHALL wrap modulo RAM_SIZE (RAM_SIZE-1 -> 0); length=RAM_SIZE SHALL write every location exactly once.
REQ-026 FINISH: SHALL assert done=1 and RESET_counter=1 for one cycle, then go to IDLE; RESETn SHALL go high in the cycle after FINISH.
REQ-027 While busy, RESETn SHALL be 0; start SHALL be ignored.
REQ-028 mar_in and ram_in SHALL never be high in the same cycle; bus_drive SHALL be 0 outside ADDR and DATA, and GLOBAL_BUS SHALL be 8'h00 whenever bus_drive=0.
REQ-029 byte_ready SHALL be high only in WAIT_BYTE; byte_valid outside WAIT_BYTE SHALL have no effect.
REQ-030 All outputs SHALL be registered or decoded from the registered state only, with no combinational path from inputs.

Reset
REQ-031 On RESET=1, SHALL immediately enter IDLE, including mid-load.
REQ-032 On RESET=1, SHALL set byte_ready, bus_drive, mar_in, ram_in, busy, done, RESET_counter=0, GLOBAL_BUS=8'h00 and count/address=0.
REQ-033 On RESET=1, SHALL set RESETn=0; RESETn SHALL stay 0 until the first load completes (FINISH), then stay 1 until the next start or RESET.
REQ-034 A load aborted by RESET SHALL NOT assert done; RAM contents already written SHALL remain as written.

Configuration
REQ-035 When the macro LOADER_CHECKSUM_EN is defined: SHALL add output checksum[7:0], cleared on start and on RESET, accumulating the sum modulo 256 of every byte written in DATA; checksum SHALL be stable from FINISH until the next start.
REQ-036 When LOADER_CHECKSUM_EN is not defined: the checksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Bench SHALL cover: start_addr=8'h10, length=3, bytes 8'hA1/8'hB2/8'hC3 with valid held high -> mar_in with bus 10/11/12, ram_in with A1/B2/C3, 3 cycles per byte, done pulse at cycle 10, RESETn high after.
REQ-038 Bench SHALL cover: start_addr=8'hFE, length=4 -> addresses FE, FF, 00, 01.
REQ-039 Bench SHALL cover: length=0 -> FINISH in the cycle after start, done=1, no mar_in/ram_in.
REQ-040 Bench SHALL cover: byte_valid low for 5 cycles in WAIT_BYTE -> byte_ready held, no strobes, resumes correctly; start pulsed mid-load is ignored.
REQ-041 Bench SHALL cover: RESET asserted during DATA of byte 2 -> all strobes 0 immediately, no done, RESETn=0, a fresh load afterwards is correct.
REQ-042 Bench SHALL cover, with LOADER_CHECKSUM_EN: bytes 8'hFF, 8'h02 -> checksum=8'h01 at done.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: streams program bytes from a byte source into the computer's RAM
// through the global bus (MAR load, then RAM write) while the CPU is held in reset.
// Optional feature macro: LOADER_CHECKSUM_EN adds an 8-bit running checksum output.
module ram_loader #(
  parameter int RAM_ADDRESS_BITS = 8,
  parameter int RAM_SIZE         = 256
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        start,
  input  logic [RAM_ADDRESS_BITS-1:0] start_addr,
  input  logic [RAM_ADDRESS_BITS:0]   length,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [7:0]                  GLOBAL_BUS,
  output logic                        bus_drive,
  output logic                        mar_in,
  output logic                        ram_in,
  output logic                        RESETn,
  output logic                        RESET_counter,
  output logic                        busy,
  output logic                        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                  checksum
`endif
);

  localparam int AW = RAM_ADDRESS_BITS;
  localparam int LW = RAM_ADDRESS_BITS + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    ADDR,
    DATA,
    FINISH
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] count_q;
  logic [7:0]    data_q;
  logic          rstn_q;
  logic          last_byte;
  logic [AW-1:0] addr_inc;

  assign last_byte = (count_q == len_q - LW'(1));
  assign addr_inc  = (addr_q == AW'(RAM_SIZE - 1)) ? '0 : addr_q + AW'(1);

  // State register
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start is only looked at in IDLE, byte_valid only in WAIT_BYTE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = (length == '0) ? FINISH : WAIT_BYTE;
      WAIT_BYTE: if (byte_valid) state_next = ADDR;
      ADDR:      state_next = DATA;
      DATA:      state_next = last_byte ? FINISH : WAIT_BYTE;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Load parameters, byte holding register and CPU reset flag
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      rstn_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= start_addr;
            len_q   <= length;
            count_q <= '0;
            rstn_q  <= 1'b0;
          end
        end
        WAIT_BYTE: if (byte_valid) data_q <= byte_in;
        DATA: begin
          if (!last_byte) begin
            count_q <= count_q + LW'(1);
            addr_q  <= addr_inc;
          end
        end
        FINISH:  rstn_q <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of bytes written to RAM; holds after FINISH until the next start
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)                       checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (state == DATA)          checksum <= checksum + data_q;
  end
`endif

  // Outputs decoded purely from registered state and data
  always_comb begin
    byte_ready    = 1'b0;
    GLOBAL_BUS    = '0;
    bus_drive     = 1'b0;
    mar_in        = 1'b0;
    ram_in        = 1'b0;
    RESET_counter = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    RESETn        = rstn_q;
    unique case (state)
      WAIT_BYTE: byte_ready = 1'b1;
      ADDR: begin
        GLOBAL_BUS = 8'(addr_q);
        bus_drive  = 1'b1;
        mar_in     = 1'b1;
      end
      DATA: begin
        GLOBAL_BUS = data_q;
        bus_drive  = 1'b1;
        ram_in     = 1'b1;
      end
      FINISH: begin
        done          = 1'b1;
        RESET_counter = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed-vector bench for ram_loader with immediate-assertion checks.
// Define LOADER_CHECKSUM_EN for both files to include the checksum scenario.
`timescale 1ns/1ps
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] global_bus;
  logic       bus_drive;
  logic       mar_in;
  logic       ram_in;
  logic       resetn;
  logic       reset_counter;
  logic       busy;
  logic       done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  ram_loader #(.RAM_ADDRESS_BITS(8), .RAM_SIZE(256)) dut (
    .clk          (clk),
    .RESET        (rst),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .GLOBAL_BUS   (global_bus),
    .bus_drive    (bus_drive),
    .mar_in       (mar_in),
    .ram_in       (ram_in),
    .RESETn       (resetn),
    .RESET_counter(reset_counter),
    .busy         (busy),
    .done         (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle and sample 1 ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Current cycle must be WAIT_BYTE with byte d presented; checks the ADDR and DATA cycles
  task automatic load_byte(input string tag, input logic [7:0] a, input logic [7:0] d);
    byte_in    = d;
    byte_valid = 1'b1;
    chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
    chk({tag, "_wait_bus"}, 32'(global_bus), 32'h00);
    cyc();
    chk({tag, "_mar"}, 32'({mar_in, ram_in, bus_drive, byte_ready}), 32'b1010);
    chk({tag, "_addr"}, 32'(global_bus), 32'(a));
    cyc();
    chk({tag, "_ram"}, 32'({mar_in, ram_in, bus_drive, byte_ready}), 32'b0110);
    chk({tag, "_data"}, 32'(global_bus), 32'(d));
  endtask

  task automatic begin_load(input logic [7:0] a, input logic [8:0] len);
    start_addr = a;
    length     = len;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  // Current cycle must be FINISH; checks it and the following IDLE cycle
  task automatic finish_chk(input string tag);
    chk({tag, "_done"}, 32'({done, reset_counter, busy, resetn}), 32'b1110);
    chk({tag, "_fin_strobes"}, 32'({mar_in, ram_in, bus_drive}), 32'b000);
    cyc();
    chk({tag, "_idle"}, 32'({done, reset_counter, busy, resetn}), 32'b0001);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    cyc();
    cyc();
    chk("rst_outs", 32'({byte_ready, bus_drive, mar_in, ram_in, busy, done, reset_counter}), 32'd0);
    chk("rst_bus", 32'(global_bus), 32'h00);
    chk("rst_resetn", 32'(resetn), 32'd0);
    rst = 1'b0;
    cyc();
    chk("idle_resetn_low", 32'(resetn), 32'd0);

    // Basic load: 10/11/12 <- A1/B2/C3, valid held high, done in cycle 10
    byte_valid = 1'b1;
    byte_in    = 8'hA1;
    begin_load(8'h10, 9'd3);
    chk("t1_busy", 32'({busy, resetn}), 32'b10);
    load_byte("t1_b0", 8'h10, 8'hA1);
    cyc();
    load_byte("t1_b1", 8'h11, 8'hB2);
    cyc();
    load_byte("t1_b2", 8'h12, 8'hC3);
    chk("t1_no_early_done", 32'(done), 32'd0);
    cyc();
    finish_chk("t1");

    // Address wrap FE, FF, 00, 01
    begin_load(8'hFE, 9'd4);
    load_byte("t2_b0", 8'hFE, 8'h11);
    cyc();
    load_byte("t2_b1", 8'hFF, 8'h22);
    cyc();
    load_byte("t2_b2", 8'h00, 8'h33);
    cyc();
    load_byte("t2_b3", 8'h01, 8'h44);
    cyc();
    finish_chk("t2");

    // Zero length: FINISH directly after start
    byte_valid = 1'b0;
    begin_load(8'h55, 9'd0);
    finish_chk("t3");

    // Source stalls 5 cycles; start pulsed mid-load is ignored
    begin_load(8'h20, 9'd2);
    for (int i = 0; i < 5; i++) begin
      start      = (i == 2);
      start_addr = 8'h99;
      length     = 9'd7;
      chk("t4_stall", 32'({byte_ready, mar_in, ram_in, bus_drive, busy, resetn}), 32'b100010);
      cyc();
    end
    start = 1'b0;
    load_byte("t4_b0", 8'h20, 8'h5A);
    cyc();
    load_byte("t4_b1", 8'h21, 8'h6B);
    cyc();
    finish_chk("t4");

    // Reset during DATA of byte 2
    begin_load(8'h30, 9'd3);
    load_byte("t5_b0", 8'h30, 8'h01);
    cyc();
    load_byte("t5_b1", 8'h31, 8'h02);
    #2 rst = 1'b1;
    #1;
    chk("t5_abort_outs", 32'({byte_ready, bus_drive, mar_in, ram_in, busy, done, reset_counter}), 32'd0);
    chk("t5_abort_bus", 32'({resetn, global_bus}), 32'h000);
    cyc();
    chk("t5_abort_nodone", 32'({done, busy, resetn}), 32'b000);
    rst        = 1'b0;
    byte_valid = 1'b0;
    cyc();
    chk("t5_after_idle", 32'({done, busy, resetn, byte_ready}), 32'b0000);
    begin_load(8'h40, 9'd1);
    load_byte("t5_new", 8'h40, 8'h77);
    cyc();
    finish_chk("t5");

`ifdef LOADER_CHECKSUM_EN
    // Checksum wraps modulo 256: FF + 02 = 01
    begin_load(8'h50, 9'd2);
    chk("t6_cs_clear", 32'(checksum), 32'h00);
    load_byte("t6_b0", 8'h50, 8'hFF);
    cyc();
    load_byte("t6_b1", 8'h51, 8'h02);
    cyc();
    chk("t6_cs_done", 32'({done, checksum}), 32'h101);
    cyc();
    cyc();
    chk("t6_cs_hold", 32'(checksum), 32'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
